// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch and data) in front of one single-port memory.
// The data port wins ties, but a fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // busy_cnt holds the number of BUSY cycles already spent, so this value marks the last one.
  localparam logic [7:0] BUSY_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic [7:0]  busy_cnt;
  logic        gnt_if;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fetch_prio;
  logic        grant_dm;
  logic        grant_if;

  assign fetch_prio = if_req_i && (starve_cnt == STARVE_LIM);
  assign grant_dm   = (state == IDLE) && dm_req_i && !fetch_prio;
  assign grant_if   = (state == IDLE) && if_req_i && !grant_dm;

  // Bus strobes decode straight from state, so an asynchronous reset drops them at once.
  assign mem_req_o   = (state == BUSY);
  assign mem_we_o    = (state == BUSY) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ready_o  = (state == RESP) && gnt_if;
  assign dm_ready_o  = (state == RESP) && !gnt_if;
  assign stall_o     = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees the
  // pre-edge values of its neighbours regardless of statement order in this block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy_cnt   <= '0;
      gnt_if     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_o <= '0;
      dm_rdata_o <= '0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            state    <= BUSY;
            busy_cnt <= '0;
            gnt_if   <= grant_if;
            addr_q   <= grant_if ? if_addr_i : dm_addr_i;
            we_q     <= grant_dm && dm_we_i;
            wdata_q  <= grant_if ? '0 : dm_wdata_i;
            if (grant_if) begin
              starve_cnt <= '0;
            end else if (if_req_i && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        BUSY: begin
          // An ack on the final cycle takes precedence over the timeout.
          if (mem_ack_i) begin
            state <= RESP;
            if (gnt_if) begin
              if_rdata_o <= mem_rdata_i;
            end else if (!we_q) begin
              dm_rdata_o <= mem_rdata_i;
            end
          end else if (busy_cnt == BUSY_LAST) begin
            state <= RESP;
            err_o <= 1'b1;
            if (gnt_if) begin
              if_rdata_o <= '0;
            end else if (!we_q) begin
              dm_rdata_o <= '0;
            end
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, tie, starvation, timeout, ack-at-boundary and reset cases.
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(15), .STARVE_MAX(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ready_o (if_ready_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_ready_o (dm_ready_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  logic [31:0] exp_addr [5];
  logic        exp_is_if [5];

  initial begin
    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick();
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    check("rst_readys", {30'd0, if_ready_o, dm_ready_o}, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Fetch only, ack in the first BUSY cycle.
    if_req_i = 1'b1; if_addr_i = 32'h10;
    #1;
    check("f_c0_stall", 32'(stall_o), 32'd1);
    check("f_c0_mem_req", 32'(mem_req_o), 32'd0);
    tick();
    check("f_c1_mem_req", 32'(mem_req_o), 32'd1);
    check("f_c1_mem_addr", mem_addr_o, 32'h10);
    check("f_c1_mem_we", 32'(mem_we_o), 32'd0);
    check("f_c1_stall", 32'(stall_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b0;
    check("f_c2_if_ready", 32'(if_ready_o), 32'd1);
    check("f_c2_dm_ready", 32'(dm_ready_o), 32'd0);
    check("f_c2_if_rdata", if_rdata_o, 32'hDEADBEEF);
    check("f_c2_stall", 32'(stall_o), 32'd0);
    check("f_c2_mem_req", 32'(mem_req_o), 32'd0);
    if_req_i = 1'b0;
    tick();
    check("f_c3_if_ready", 32'(if_ready_o), 32'd0);

    // Simultaneous data write and fetch: data goes first.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h40; dm_wdata_i = 32'h5;
    if_req_i = 1'b1; if_addr_i = 32'h8;
    tick();
    check("t_dm_mem_we", 32'(mem_we_o), 32'd1);
    check("t_dm_mem_addr", mem_addr_o, 32'h40);
    check("t_dm_mem_wdata", mem_wdata_o, 32'h5);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    mem_ack_i = 1'b0;
    check("t_dm_ready", 32'(dm_ready_o), 32'd1);
    check("t_dm_if_ready", 32'(if_ready_o), 32'd0);
    check("t_dm_rdata_kept", dm_rdata_o, 32'd0);
    check("t_dm_mem_we_resp", 32'(mem_we_o), 32'd0);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();
    check("t_idle_mem_req", 32'(mem_req_o), 32'd0);
    tick();
    check("t_if_mem_addr", mem_addr_o, 32'h8);
    check("t_if_mem_we", 32'(mem_we_o), 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    mem_ack_i = 1'b0;
    check("t_if_ready", 32'(if_ready_o), 32'd1);
    check("t_if_rdata", if_rdata_o, 32'hCAFEF00D);
    check("t_if_dm_rdata", dm_rdata_o, 32'd0);
    if_req_i = 1'b0;
    tick();

    // Starvation: both requests held, ack always high.
    exp_addr[0] = 32'h100; exp_is_if[0] = 1'b0;
    exp_addr[1] = 32'h100; exp_is_if[1] = 1'b0;
    exp_addr[2] = 32'h100; exp_is_if[2] = 1'b0;
    exp_addr[3] = 32'h200; exp_is_if[3] = 1'b1;
    exp_addr[4] = 32'h100; exp_is_if[4] = 1'b0;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
    if_req_i = 1'b1; if_addr_i = 32'h200;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A50000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s%0d_mem_addr", i), mem_addr_o, exp_addr[i]);
      tick();
      check($sformatf("s%0d_if_ready", i), 32'(if_ready_o), 32'(exp_is_if[i]));
      check($sformatf("s%0d_dm_ready", i), 32'(dm_ready_o), 32'(!exp_is_if[i]));
      tick();
    end
    dm_req_i = 1'b0; if_req_i = 1'b0; mem_ack_i = 1'b0;
    check("s_dm_rdata", dm_rdata_o, 32'hA5A50000);
    tick();

    // Timeout on a data read.
    dm_req_i = 1'b1; dm_addr_i = 32'h300;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("to_c15_mem_req", 32'(mem_req_o), 32'd1);
    check("to_c15_err", 32'(err_o), 32'd0);
    tick();
    check("to_resp_dm_ready", 32'(dm_ready_o), 32'd1);
    check("to_resp_dm_rdata", dm_rdata_o, 32'd0);
    check("to_resp_err", 32'(err_o), 32'd1);
    dm_req_i = 1'b0;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h20;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11;
    tick();
    mem_ack_i = 1'b0;
    check("to_after_if_rdata", if_rdata_o, 32'h11);
    check("to_after_err", 32'(err_o), 32'd1);
    if_req_i = 1'b0;
    tick();

    // Reset clears the sticky error; then ack lands exactly on BUSY cycle 15.
    rst_i = 1'b1;
    #1;
    check("rst2_err", 32'(err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'h400;
    tick();
    for (int i = 0; i < 13; i++) tick();
    check("bd_c14_mem_req", 32'(mem_req_o), 32'd1);
    tick();
    check("bd_c15_mem_req", 32'(mem_req_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADCAFE;
    tick();
    mem_ack_i = 1'b0;
    check("bd_dm_ready", 32'(dm_ready_o), 32'd1);
    check("bd_dm_rdata", dm_rdata_o, 32'h0BADCAFE);
    check("bd_err", 32'(err_o), 32'd0);
    dm_req_i = 1'b0;
    tick();

    // Reset asserted mid-BUSY, then a stray ack in IDLE.
    dm_req_i = 1'b1; dm_addr_i = 32'h500;
    tick();
    check("rb_mem_req_busy", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rb_mem_req_rst", 32'(mem_req_o), 32'd0);
    check("rb_mem_addr_rst", mem_addr_o, 32'd0);
    dm_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    tick();
    check("rb_stray_dm_ready", 32'(dm_ready_o), 32'd0);
    check("rb_stray_mem_req", 32'(mem_req_o), 32'd0);
    tick();
    check("rb_stray_readys", {30'd0, if_ready_o, dm_ready_o}, 32'd0);
    check("rb_stray_dm_rdata", dm_rdata_o, 32'd0);
    mem_ack_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
